// File: rtl/puf_response_sampler_pkg.sv
// Shared PUF datapath definitions: FSM state encoding, default run constants
// and a width helper for the sampler counters.
package puf_response_sampler_pkg;

  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_VOTES         = 7;
  localparam int DEF_BITS          = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRE   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous clear, used to bring the raw
// arbiter output into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/puf_response_sampler.sv
// Launches the delay PUF VOTES times per response bit, samples the synchronized
// arbiter output after settling and emits the majority bit with a 1-cycle strobe.
module puf_response_sampler
  import puf_response_sampler_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int VOTES         = DEF_VOTES,
  parameter int BITS          = DEF_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       puf_resp,
  output logic       puf_fire,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  localparam int VW = clog2_min1(VOTES + 1);
  localparam int SW = clog2_min1(SETTLE_CYCLES);
  localparam int BW = clog2_min1(BITS);

  localparam logic [VW-1:0] VOTES_LAST  = VW'(VOTES - 1);
  localparam logic [VW-1:0] VOTES_HALF  = VW'(VOTES / 2);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(BITS - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [SW-1:0] r_settle_cnt;
  logic [SW-1:0] w_settle_nxt;
  logic [VW-1:0] r_vote_cnt;
  logic [VW-1:0] w_vote_nxt;
  logic [VW-1:0] r_ones_cnt;
  logic [VW-1:0] w_ones_nxt;
  logic [BW-1:0] r_bit_idx;
  logic [BW-1:0] w_bit_idx_nxt;
  logic          w_resp_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (puf_resp),
    .q     (w_resp_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_vote_cnt   <= '0;
      r_ones_cnt   <= '0;
      r_bit_idx    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_vote_cnt   <= w_vote_nxt;
      r_ones_cnt   <= w_ones_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle_cnt;
    w_vote_nxt    = r_vote_cnt;
    w_ones_nxt    = r_ones_cnt;
    w_bit_idx_nxt = r_bit_idx;
    puf_fire      = 1'b0;
    bit_out       = 1'b0;
    bit_valid     = 1'b0;
    done          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt   = ST_FIRE;
          w_vote_nxt    = '0;
          w_ones_nxt    = '0;
          w_bit_idx_nxt = '0;
        end
      end
      ST_FIRE: begin
        puf_fire     = 1'b1;
        w_settle_nxt = SETTLE_LOAD;
        w_state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_settle_nxt = r_settle_cnt - SW'(1);
        end
      end
      ST_SAMPLE: begin
        w_ones_nxt  = r_ones_cnt + VW'(w_resp_sync);
        w_vote_nxt  = r_vote_cnt + VW'(1);
        w_state_nxt = (r_vote_cnt == VOTES_LAST) ? ST_EMIT : ST_FIRE;
      end
      ST_EMIT: begin
        // Strict compare: an (unsupported) even-VOTES tie resolves to 0.
        bit_out    = (r_ones_cnt > VOTES_HALF);
        bit_valid  = 1'b1;
        w_ones_nxt = '0;
        w_vote_nxt = '0;
        if (r_bit_idx == BIT_LAST) begin
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_bit_idx_nxt = r_bit_idx + BW'(1);
          w_state_nxt   = ST_FIRE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a strobe in the same cycle.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_settle_nxt  = '0;
      w_vote_nxt    = '0;
      w_ones_nxt    = '0;
      w_bit_idx_nxt = '0;
      bit_out       = 1'b0;
      bit_valid     = 1'b0;
      done          = 1'b0;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule
